// File: rtl/tick_period_monitor.sv
// Consumer-side checker for a divider's enable tick: measures the rise-to-rise
// spacing in CLK cycles, locks onto an expected period, and counts period errors.
module tick_period_monitor #(
  parameter int          CNT_W      = 8,
  parameter int          LOCK_COUNT = 4,
  parameter int          TIMEOUT    = 255,
  parameter logic [15:0] ERR_MAX    = 16'hFFFF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clear,
  input  logic             tick_in,
  input  logic [CNT_W-1:0] expected,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [15:0]      err_count,
  output logic             timeout_flag,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_ACQUIRE = 2'd2;
  localparam logic [1:0] S_LOCKED  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LOCK_C    = 4'(LOCK_COUNT);

  logic [1:0]       state, state_d;
  logic [CNT_W-1:0] interval, interval_d;
  logic [3:0]       match_cnt, match_cnt_d, match_inc;
  logic             tick_prev;
  logic             rise, match, timeout_hit;
  logic             pv_d, err_d, to_d;

  // period_valid is a one-cycle strobe with no back-pressure: the consumer must
  // capture period in the cycle period_valid is high.
  assign rise        = tick_in & ~tick_prev;
  assign match       = (expected != '0) && (interval == expected);
  assign match_inc   = match_cnt + 4'd1;
  assign timeout_hit = (state != S_IDLE) && !rise && (interval >= TIMEOUT_C);

  always_comb begin
    state_d     = state;
    match_cnt_d = match_cnt;
    pv_d        = 1'b0;
    err_d       = 1'b0;
    to_d        = 1'b0;
    interval_d  = interval;

    if (rise)
      interval_d = CNT_ONE;
    else if ((state != S_IDLE) && (interval != CNT_MAX))
      interval_d = interval + CNT_ONE;

    case (state)
      S_IDLE: begin
        if (rise)
          state_d = S_ARMED;
      end
      S_ARMED: begin
        if (rise) begin
          pv_d = 1'b1;
          if (match) begin
            match_cnt_d = 4'd1;
            state_d     = (LOCK_C == 4'd1) ? S_LOCKED : S_ACQUIRE;
          end else begin
            match_cnt_d = 4'd0;
            state_d     = S_ACQUIRE;
          end
        end
      end
      S_ACQUIRE: begin
        if (rise) begin
          pv_d = 1'b1;
          if (match) begin
            match_cnt_d = match_inc;
            if (match_inc >= LOCK_C)
              state_d = S_LOCKED;
          end else begin
            match_cnt_d = 4'd0;
          end
        end
      end
      default: begin
        if (rise) begin
          pv_d = 1'b1;
          if (!match) begin
            err_d       = 1'b1;
            match_cnt_d = 4'd0;
            state_d     = S_ACQUIRE;
          end
        end
      end
    endcase

    // A rise on the same cycle suppresses the timeout (see timeout_hit).
    if (timeout_hit) begin
      state_d     = S_IDLE;
      interval_d  = '0;
      match_cnt_d = 4'd0;
      to_d        = 1'b1;
      err_d       = (state == S_LOCKED);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= S_IDLE;
      interval     <= '0;
      match_cnt    <= 4'd0;
      tick_prev    <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      err_pulse    <= 1'b0;
      err_count    <= 16'd0;
      timeout_flag <= 1'b0;
    end else begin
      // The edge detector keeps tracking during clear so a held tick is not
      // seen as a fresh rise once clear drops.
      tick_prev <= tick_in;
      if (clear) begin
        state        <= S_IDLE;
        interval     <= '0;
        match_cnt    <= 4'd0;
        period       <= '0;
        period_valid <= 1'b0;
        err_pulse    <= 1'b0;
        err_count    <= 16'd0;
        timeout_flag <= 1'b0;
      end else begin
        state        <= state_d;
        interval     <= interval_d;
        match_cnt    <= match_cnt_d;
        period_valid <= pv_d;
        err_pulse    <= err_d;
        if (pv_d)
          period <= interval;
        if (err_d && (err_count != ERR_MAX))
          err_count <= err_count + 16'd1;
        if (to_d)
          timeout_flag <= 1'b1;
      end
    end
  end

  assign locked    = (state == S_LOCKED);
  assign state_dbg = state;

endmodule

// File: doc/tick_period_monitor.md
Name: tick_period_monitor

Overview:
- Consumer-side checker for the enable_tick strobe emitted by the clock divider.
- Measures the CLK-cycle spacing between rising edges of the tick and compares each period against an expected division value.
- Declares lock after a run of consecutive matching periods, then counts period errors.
- Flags a stuck or absent tick with a timeout.
- Sits beside the divider in QC firmware; status is read by the slow-control register bank.

Parameters:
CNT_W, 8, width of interval counter, period and expected.
LOCK_COUNT, 4, consecutive matching periods required to enter LOCKED (range 1..15).
TIMEOUT, 255, CLK cycles since the last rising edge, without a new edge, that trigger timeout (must be < 2^CNT_W).

Ports:
CLK  in  1  system clock.
RST  in  1  reset, asynchronous, active-high.
clear  in  1  synchronous clear; same effect as RST on all state, counters and flags.
tick_in  in  1  tick/enable strobe under test; synchronous to CLK; pulse or held level.
expected  in  CNT_W  expected period in CLK cycles; 0 disables comparison.
period  out  CNT_W  last measured period.
period_valid  out  1  one-cycle pulse when period updates.
locked  out  1  high while the FSM is in LOCKED.
err_pulse  out  1  one-cycle pulse on a period mismatch while LOCKED, or on a timeout while LOCKED.
err_count  out  16  saturating error count; stops at 16'hFFFF.
timeout_flag  out  1  sticky; set on timeout; cleared only by RST or clear.

Behaviour:
- Reset values: all outputs 0, state IDLE, interval counter 0, tick_prev 0, match_cnt 0.
- Edge detect: `rise = tick_in & ~tick_prev`; tick_prev is registered every cycle. A held-high tick gives exactly one rise.
- Interval counter:
  - Loads 1 on the cycle rise is true.
  - Otherwise increments by 1 while state != IDLE.
  - Saturates at 2^CNT_W-1.
- Measured period: rises sampled at cycles t and t+N give period N (for example, a single-cycle pulse every 5 cycles gives period 5).
- Latency: period and period_valid register on the edge that samples rise, so they are visible 1 cycle after tick_in is first sampled high.
- Match definition: `match = (expected != 0) && (measured == expected)`. It is evaluated on the same edge, using the pre-load counter value.
- FSM:
  - IDLE: on rise -> ARMED. No period is produced.
  - ARMED: on rise -> emit period. If match, match_cnt = 1 and go to ACQUIRE (or to LOCKED if LOCK_COUNT == 1); else match_cnt = 0 and go to ACQUIRE.
  - ACQUIRE:
    - On rise with match: match_cnt+1. When match_cnt+1 == LOCK_COUNT -> LOCKED.
    - On rise without match: match_cnt = 0. No error is counted.
  - LOCKED:
    - On rise with match: stay.
    - On rise without match: err_pulse, err_count+1, match_cnt = 0 -> ACQUIRE. locked drops the same cycle the state changes.
- Timeout:
  - Condition: state in {ARMED, ACQUIRE, LOCKED} and the counter reaches TIMEOUT with no rise in that cycle.
  - Response: timeout_flag = 1, go to IDLE, counter = 0, match_cnt = 0, no period_valid.
  - If the state was LOCKED, also err_pulse and err_count+1.
  - A rise on the timeout cycle takes priority: it is treated as a normal edge and no timeout occurs.
- expected == 0: the FSM never leaves ACQUIRE via match, locked stays 0, no errors. Periods are still reported.
- expected change mid-run: takes effect on the next evaluated rise, with no other side effect.
- Simultaneous clear and rise: clear wins; the rise is discarded (tick_prev still updates).
- RST mid-measurement: asynchronously returns everything to reset values. The first rise after deassertion only arms the FSM.
- err_count at 16'hFFFF: further errors still pulse err_pulse but the count holds.

Test Plan:
- RST, expected=5, single-cycle tick every 5 cycles -> period=5 on each period_valid; locked rises with the 4th matching period (5th edge); err_count=0.
- Locked at 5, one gap of 6 cycles -> period=6, err_pulse once, err_count=1, locked=0. After 4 more 5-cycle gaps, locked=1 again.
- Locked, then tick_in held high continuously (divider behaviour once the count reaches div-1) -> no further rise; after 255 cycles timeout_flag=1, err_count+1, locked=0, state IDLE. The next rise only arms the FSM.
- expected=0, ticks every 3 cycles -> period=3 pulses, locked stays 0, err_count stays 0, timeout_flag=0.
- clear asserted on the same cycle as a rise while locked -> all outputs 0 next cycle, no period_valid. The following two rises 5 cycles apart give period=5.
- Force err_count to 16'hFFFF (preload via 65535 mismatches, or a short-count build) then one more mismatch -> err_pulse=1, err_count stays 16'hFFFF.
